mem_sync_arbiter: RTL and testbench

Parametrised successor to the two-port memory stall controller. It sits between the CPU's N_CH memory ports (instruction fetch, data, and any additional ones) and the bus masters that serve them. It forwards each CPU request to its bus channel and tracks which channels have not yet completed. It holds the CPU stalled until every issued channel has reported ready, and never re-issues a channel that has already completed within the same access. An optional watchdog aborts accesses that hang.

---
 rtl/mem_sync_pkg.sv | 13 +
 rtl/mem_sync_watchdog.sv | 40 ++++
 rtl/mem_sync_arbiter.sv | 92 +++++++++
 tb/tb_mem_sync_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the memory channel stall arbiter.
package mem_sync_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_sync_watchdog.sv
// WAIT-cycle counter that flags an abort when an access has hung for
// TIMEOUT_CYCLES WAIT cycles.
import mem_sync_pkg::*;

module mem_sync_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  state_e state_i,
  input  logic   busy_i,
  output logic   abort_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clearing throughout IDLE is equivalent to clearing on entry to WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_i == ST_IDLE) begin
      cnt_d = '0;
    end else if (busy_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign abort_o = (state_i == ST_WAIT) && busy_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_sync_arbiter.sv
// Multi-channel memory stall arbiter: forwards CPU requests per channel and
// stalls until all issued channels complete. Watchdog: MEM_SYNC_WATCHDOG_EN.
import mem_sync_pkg::*;

module mem_sync_arbiter #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] cpu_rd_i,
  input  logic [N_CH-1:0] cpu_wr_i,
  output logic [N_CH-1:0] bus_rd_o,
  output logic [N_CH-1:0] bus_wr_o,
  input  logic [N_CH-1:0] bus_ready_i,
  output logic            mem_ready_o,
  output logic [N_CH-1:0] pending_o,
  output logic            timeout_o,
  output logic [N_CH-1:0] timeout_ch_o
);

  state_e          state_q;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] active, issue_raw, issue;
  logic            busy;
  logic            abort;

  always_comb begin
    active = cpu_rd_i | cpu_wr_i;
    if (state_q == ST_IDLE) begin
      issue_raw = active;
      pending_d = active & ~bus_ready_i;
    end else begin
      issue_raw = active & pending_q;
      pending_d = pending_q & ~bus_ready_i;
    end
  end

  assign busy  = |pending_d;
  assign issue = abort ? '0 : issue_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= busy ? ST_WAIT : ST_IDLE;
      pending_q <= pending_d;
    end
  end

`ifdef MEM_SYNC_WATCHDOG_EN
  logic [N_CH-1:0] timeout_ch_q;

  mem_sync_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .state_i(state_q),
    .busy_i (busy),
    .abort_o(abort)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_ch_q <= '0;
    end else if (abort) begin
      timeout_ch_q <= pending_d;
    end
  end

  assign timeout_ch_o = timeout_ch_q;
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign timeout_ch_o   = '0;
  assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

  // Outputs are held low for the whole reset pulse, not just after the edge.
  assign bus_rd_o    = rst_i ? '0 : (cpu_rd_i & issue);
  assign bus_wr_o    = rst_i ? '0 : (cpu_wr_i & issue);
  assign mem_ready_o = !rst_i && (!busy || abort);
  assign timeout_o   = !rst_i && abort;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Scoreboard bench for mem_sync_arbiter: one N_CH=2 and one N_CH=4 instance.
module tb_mem_sync_arbiter;

  localparam int unsigned TO = 4;
`ifdef MEM_SYNC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk, rst;
  logic [1:0] d2_rd, d2_wr, d2_rdy, d2_brd, d2_bwr, d2_pend, d2_tch;
  logic [3:0] d4_rd, d4_wr, d4_rdy, d4_brd, d4_bwr, d4_pend, d4_tch;
  logic       d2_mr, d2_to, d4_mr, d4_to;

  logic [3:0] rd_s[2], wr_s[2], rdy_s[2];

  assign d2_rd  = rd_s[0][1:0];
  assign d2_wr  = wr_s[0][1:0];
  assign d2_rdy = rdy_s[0][1:0];
  assign d4_rd  = rd_s[1];
  assign d4_wr  = wr_s[1];
  assign d4_rdy = rdy_s[1];

  mem_sync_arbiter #(.N_CH(2), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk_i(clk), .rst_i(rst), .cpu_rd_i(d2_rd), .cpu_wr_i(d2_wr),
    .bus_rd_o(d2_brd), .bus_wr_o(d2_bwr), .bus_ready_i(d2_rdy),
    .mem_ready_o(d2_mr), .pending_o(d2_pend), .timeout_o(d2_to),
    .timeout_ch_o(d2_tch)
  );

  mem_sync_arbiter #(.N_CH(4), .TIMEOUT_CYCLES(TO)) dut4 (
    .clk_i(clk), .rst_i(rst), .cpu_rd_i(d4_rd), .cpu_wr_i(d4_wr),
    .bus_rd_o(d4_brd), .bus_wr_o(d4_bwr), .bus_ready_i(d4_rdy),
    .mem_ready_o(d4_mr), .pending_o(d4_pend), .timeout_o(d4_to),
    .timeout_ch_o(d4_tch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic       mr;
    logic [3:0] brd, bwr, pend, tch;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0]  m_pend[2], m_tch[2];
  logic        m_st[2], m_lastready[2];
  int unsigned m_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0; m_tch[d] = '0; m_st[d] = 1'b0; m_cnt[d] = 0;
      m_lastready[d] = 1'b1;
      rd_s[d] = '0; wr_s[d] = '0; rdy_s[d] = '0;
    end
  endtask

  // One clock cycle: predict both DUTs from the spec model, sample, compare.
  task automatic cyc();
    exp_t e;
    logic [3:0] mask, act, iss, pn;
    logic ab;
    for (int d = 0; d < 2; d++) begin
      mask = (d == 0) ? 4'h3 : 4'hF;
      act  = (rd_s[d] | wr_s[d]) & mask;
      if (!m_st[d]) begin
        iss = act;
        pn  = act & ~rdy_s[d];
      end else begin
        iss = act & m_pend[d];
        pn  = m_pend[d] & ~rdy_s[d] & mask;
      end
      ab = WD && m_st[d] && (pn != 0) && (m_cnt[d] == TO - 1);
      if (ab) iss = '0;
      e.d = d; e.mr = (pn == 0) || ab; e.brd = rd_s[d] & iss; e.bwr = wr_s[d] & iss;
      e.pend = m_pend[d]; e.tch = m_tch[d]; e.to = ab;
      sb.push_back(e);
      m_lastready[d] = e.mr;
      if (ab) begin
        m_tch[d] = pn; m_pend[d] = '0; m_st[d] = 1'b0;
      end else begin
        if (!m_st[d] && pn != 0) m_cnt[d] = 0;
        else if (m_st[d] && pn != 0) m_cnt[d]++;
        m_pend[d] = pn;
        m_st[d]   = (pn != 0);
      end
    end
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        check("n2 mem_ready", {31'b0, d2_mr}, {31'b0, e.mr});
        check("n2 bus_rd", {30'b0, d2_brd}, {28'b0, e.brd});
        check("n2 bus_wr", {30'b0, d2_bwr}, {28'b0, e.bwr});
        check("n2 pending", {30'b0, d2_pend}, {28'b0, e.pend});
        check("n2 timeout", {31'b0, d2_to}, {31'b0, e.to});
        check("n2 timeout_ch", {30'b0, d2_tch}, {28'b0, e.tch});
      end else begin
        check("n4 mem_ready", {31'b0, d4_mr}, {31'b0, e.mr});
        check("n4 bus_rd", {28'b0, d4_brd}, {28'b0, e.brd});
        check("n4 bus_wr", {28'b0, d4_bwr}, {28'b0, e.bwr});
        check("n4 pending", {28'b0, d4_pend}, {28'b0, e.pend});
        check("n4 timeout", {31'b0, d4_to}, {31'b0, e.to});
        check("n4 timeout_ch", {28'b0, d4_tch}, {28'b0, e.tch});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic t2(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] rdy);
    rd_s[0] = rd; wr_s[0] = wr; rdy_s[0] = rdy;
    rd_s[1] = '0; wr_s[1] = '0; rdy_s[1] = '0;
    cyc();
  endtask

  task automatic t4(input logic [3:0] rd, input logic [3:0] rdy);
    rd_s[1] = rd; wr_s[1] = '0; rdy_s[1] = rdy;
    rd_s[0] = '0; wr_s[0] = '0; rdy_s[0] = '0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset pending n2", {30'b0, d2_pend}, 32'h0);
    check("reset pending n4", {28'b0, d4_pend}, 32'h0);
    check("reset mem_ready n2", {31'b0, d2_mr}, 32'h0);
    check("reset timeout_ch n4", {28'b0, d4_tch}, 32'h0);
    rst = 1'b0;

    // ch0 rd + ch1 wr, both ready same cycle; back-to-back repeat
    t2(4'b0001, 4'b0010, 4'b0011);
    t2(4'b0001, 4'b0010, 4'b0011);
    t2(4'b0000, 4'b0000, 4'b0000);

    // out-of-order completion: ch1 in cycle 0, ch0 in cycle 3
    t2(4'b0011, 4'b0000, 4'b0010);
    t2(4'b0011, 4'b0000, 4'b0000);
    t2(4'b0011, 4'b0000, 4'b0000);
    t2(4'b0011, 4'b0000, 4'b0001);
    t2(4'b0000, 4'b0000, 4'b0000);

    // four channels completing ch2, ch0, ch3, ch1
    t4(4'b1111, 4'b0000);
    t4(4'b1111, 4'b0100);
    t4(4'b1111, 4'b0001);
    t4(4'b1111, 4'b1000);
    t4(4'b1111, 4'b0010);
    t4(4'b0000, 4'b0000);

    // hung ch1: aborts in the 4th WAIT cycle with the watchdog, else waits
    t2(4'b0011, 4'b0000, 4'b0001);
    for (int i = 0; i < 4; i++) t2(4'b0011, 4'b0000, 4'b0000);
    t2(4'b0011, 4'b0000, 4'b0011);
    t2(4'b0000, 4'b0000, 4'b0000);

    // ch1 ready in exactly the 4th WAIT cycle
    t2(4'b0011, 4'b0000, 4'b0001);
    for (int i = 0; i < 3; i++) t2(4'b0011, 4'b0000, 4'b0000);
    t2(4'b0011, 4'b0000, 4'b0010);
    t2(4'b0000, 4'b0000, 4'b0000);

    // reset mid-WAIT with pending 11
    t2(4'b0011, 4'b0000, 4'b0000);
    t2(4'b0011, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    check("rst bus_rd n2", {30'b0, d2_brd}, 32'h0);
    check("rst mem_ready n2", {31'b0, d2_mr}, 32'h0);
    check("rst pending n2", {30'b0, d2_pend}, 32'h0);
    check("rst timeout n2", {31'b0, d2_to}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    t2(4'b0000, 4'b0000, 4'b0000);

    // random traffic that respects the hold-while-stalled rule
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (m_lastready[d]) begin
          rd_s[d] = 4'($urandom);
          wr_s[d] = 4'($urandom) & ~rd_s[d];
          if (d == 0) begin
            rd_s[d] &= 4'h3;
            wr_s[d] &= 4'h3;
          end
        end
        rdy_s[d] = 4'($urandom);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
